// File: rtl/coef_bank_wb.sv
// Biquad coefficient bank with a Wishbone slave port.
// Host writes land in a shadow bank. A committed shadow bank is copied into the
// active bank in one edge on the next filter sample strobe, so the cascaded
// biquad datapath never sees a mix of old and new coefficients.
module coef_bank_wb #(
    parameter int unsigned NSEC  = 3,
    parameter int unsigned SEC_W = 2,
    parameter int unsigned CW    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [SEC_W+2:0]     adr_i,
    input  logic [15:0]          dat_i,
    output logic [15:0]          dat_o,
    output logic                 ack_o,
    output logic                 err_o,
    input  logic                 sample_stb_i,
    output logic [NSEC*5*CW-1:0] coef_o,
    output logic                 pending_o,
    output logic                 commit_o
);

    localparam int unsigned NSLOT  = NSEC * 5;
    localparam int unsigned SLOT_W = $clog2(NSLOT);

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   shadow_q [NSLOT];
    logic [CW-1:0]   shadow_d [NSLOT];
    logic [CW-1:0]   active_q [NSLOT];
    logic [CW-1:0]   active_d [NSLOT];
    logic [7:0]      cnt_q, cnt_d;
    logic [15:0]     dat_q, dat_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            commit_q, commit_d;

    logic [2:0]        idx;
    logic [SEC_W-1:0]  sec;
    logic              is_ctrl;
    logic              coef_ok;
    logic [SLOT_W-1:0] slot;
    logic [CW-1:0]     wdata;
    logic [15:0]       rdata;
    logic              access;
    logic              copy;

    assign idx    = adr_i[2:0];
    assign sec    = adr_i[SEC_W+2:3];
    assign wdata  = dat_i[15 -: CW];
    assign access = cyc_i & stb_i & ~ack_q & ~err_q;
    assign copy   = (state_q == ST_PEND) && sample_stb_i;

    // Address decode: CTRL is aliased in every section, coefficient slots need a valid section.
    always_comb begin
        is_ctrl = (idx == 3'd7);
        coef_ok = (idx < 3'd5) && (NSEC > 32'(sec));
        // Truncation only matters for out-of-range sections, which are never used.
        slot    = SLOT_W'(sec) * SLOT_W'(5) + SLOT_W'(idx);
        rdata   = '0;
        if (coef_ok) begin
            rdata = 16'(shadow_q[slot]) << (16 - CW);
        end
    end

    // Next-state: commit FSM, bus response and bank updates.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        dat_d    = dat_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        commit_d = 1'b0;

        // A strobe in PEND copies the whole bank; a same-edge cancel is then moot.
        if (copy) begin
            active_d = shadow_q;
            state_d  = ST_IDLE;
            commit_d = 1'b1;
            cnt_d    = cnt_q + 8'd1;
        end

        if (access) begin
            if (is_ctrl) begin
                ack_d = 1'b1;
                if (we_i) begin
                    dat_d = '0;
                    if (dat_i[2]) begin
                        state_d = ST_IDLE;
                    end else if (dat_i[0] && (state_q == ST_IDLE)) begin
                        state_d = ST_PEND;
                    end
                end else begin
                    dat_d = {cnt_q, 5'b0, 1'b0, (state_q == ST_PEND), 1'b0};
                end
            end else if (!coef_ok) begin
                err_d = 1'b1;
                dat_d = '0;
            end else if (we_i) begin
                dat_d = '0;
                if (state_q == ST_PEND) begin
                    // Shadow is frozen while a commit waits for its strobe.
                    err_d = 1'b1;
                end else begin
                    ack_d          = 1'b1;
                    shadow_d[slot] = wdata;
                end
            end else begin
                ack_d = 1'b1;
                dat_d = rdata;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
            cnt_q    <= '0;
            dat_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            commit_q <= commit_d;
        end
    end

    for (genvar k = 0; k < NSLOT; k++) begin : g_coef
        assign coef_o[k*CW +: CW] = active_q[k];
    end

    assign dat_o     = dat_q;
    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign pending_o = (state_q == ST_PEND);
    assign commit_o  = commit_q;

endmodule
